// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-training bundle around branch_resolve_queue.
interface branch_resolve_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             enq_valid;
  logic             enq_ready;
  logic [PC_W-1:0]  enq_pc;
  logic             enq_pred_taken;
  logic             enq_pred_branch;
  logic             res_valid;
  logic             res_taken;
  logic             res_is_branch;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic             upd_is_branch;
  logic             mispredict;
  logic [OCC_W-1:0] occupancy;
  logic             underflow_err;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] correct_cnt;

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_pred_branch,
           res_valid, res_taken, res_is_branch,
    output enq_ready, upd_valid, upd_pc, upd_taken, upd_is_branch,
           mispredict, occupancy, underflow_err, total_cnt, correct_cnt
  );

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_pred_branch,
           res_valid, res_taken, res_is_branch,
    input  enq_ready, upd_valid, upd_pc, upd_taken, upd_is_branch,
           mispredict, occupancy, underflow_err, total_cnt, correct_cnt
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch predictions; checks them at resolve, trains the
// predictor, flushes on mispredict and keeps accuracy counters.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  branch_resolve_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic             pt_mem [DEPTH];
  logic             pb_mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             uf_q, uf_d;
  logic             upd_valid_q, mis_q;
  logic [PC_W-1:0]  upd_pc_q;
  logic             upd_taken_q, upd_br_q;
  logic [CNT_W-1:0] total_q, total_d, correct_q, correct_d;

  logic enq_ready, enq_fire, res_act, res_fire, mis;
  logic head_pt, head_pb;

  always_comb begin
    enq_ready = (state_q == ST_RUN) && (occ_q != FULL);
    enq_fire  = bus.enq_valid && enq_ready;
    res_act   = bus.res_valid && (state_q == ST_RUN);
    res_fire  = res_act && (occ_q != '0);
    head_pt   = pt_mem[rd_ptr_q];
    head_pb   = pb_mem[rd_ptr_q];
    mis       = res_fire && ((head_pb != bus.res_is_branch) ||
                             (bus.res_is_branch && (head_pt != bus.res_taken)));

    state_d   = ST_RUN;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    uf_d      = uf_q || (res_act && (occ_q == '0));
    total_d   = total_q;
    correct_d = correct_q;

    // A mispredict flushes everything, including a same-cycle enqueue.
    if (mis) begin
      state_d  = ST_RECOVER;
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (res_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !res_fire) occ_d = occ_q + OCC_W'(1);
      if (!enq_fire && res_fire) occ_d = occ_q - OCC_W'(1);
    end

    if (res_fire && bus.res_is_branch) begin
      if (total_q != '1) total_d = total_q + CNT_W'(1);
      if ((head_pt == bus.res_taken) && (correct_q != '1))
        correct_d = correct_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !mis) begin
      pc_mem[wr_ptr_q] <= bus.enq_pc;
      pt_mem[wr_ptr_q] <= bus.enq_pred_taken;
      pb_mem[wr_ptr_q] <= bus.enq_pred_branch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      uf_q        <= 1'b0;
      upd_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_br_q    <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      uf_q        <= uf_d;
      upd_valid_q <= res_fire;
      mis_q       <= mis;
      total_q     <= total_d;
      correct_q   <= correct_d;
      if (res_fire) begin
        upd_pc_q    <= pc_mem[rd_ptr_q];
        upd_taken_q <= bus.res_taken;
        upd_br_q    <= bus.res_is_branch;
      end
    end
  end

  assign bus.enq_ready     = enq_ready;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_pc        = upd_pc_q;
  assign bus.upd_taken     = upd_taken_q;
  assign bus.upd_is_branch = upd_br_q;
  assign bus.mispredict    = mis_q;
  assign bus.occupancy     = occ_q;
  assign bus.underflow_err = uf_q;
  assign bus.total_cnt     = total_q;
  assign bus.correct_cnt   = correct_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed vector table plus hand sequences for branch_resolve_queue.
module tb_branch_resolve_queue;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  branch_resolve_queue_if #(.DEPTH(8), .PC_W(32), .CNT_W(32)) bus ();

  branch_resolve_queue #(.DEPTH(8), .PC_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic        ept;
    logic        epb;
    logic        rv;
    logic        rt;
    logic        rb;
    logic        rdy;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        ub;
    logic        mis;
    int          occ;
    logic        uf;
    int          tot;
    int          cor;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ev, logic [31:0] epc, logic ept, logic epb,
                              logic rv, logic rt, logic rb,
                              logic rdy, logic uv, logic [31:0] upc, logic ut,
                              logic ub, logic mis, int occ, logic uf, int tot,
                              int cor);
    vec_t v;
    v.ev = ev; v.epc = epc; v.ept = ept; v.epb = epb;
    v.rv = rv; v.rt = rt; v.rb = rb;
    v.rdy = rdy; v.uv = uv; v.upc = upc; v.ut = ut; v.ub = ub; v.mis = mis;
    v.occ = occ; v.uf = uf; v.tot = tot; v.cor = cor;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] epc, input logic ept,
                       input logic epb, input logic rv, input logic rt, input logic rb);
    bus.enq_valid       = ev;
    bus.enq_pc          = epc;
    bus.enq_pred_taken  = ept;
    bus.enq_pred_branch = epb;
    bus.res_valid       = rv;
    bus.res_taken       = rt;
    bus.res_is_branch   = rb;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " upd_valid"}, 64'(bus.upd_valid), 64'd0);
    chk({tag, " upd_pc"},    64'(bus.upd_pc), 64'd0);
    chk({tag, " upd_taken"}, 64'(bus.upd_taken), 64'd0);
    chk({tag, " upd_br"},    64'(bus.upd_is_branch), 64'd0);
    chk({tag, " mispred"},   64'(bus.mispredict), 64'd0);
    chk({tag, " occ"},       64'(bus.occupancy), 64'd0);
    chk({tag, " uflow"},     64'(bus.underflow_err), 64'd0);
    chk({tag, " total"},     64'(bus.total_cnt), 64'd0);
    chk({tag, " correct"},   64'(bus.correct_cnt), 64'd0);
    chk({tag, " enq_ready"}, 64'(bus.enq_ready), 64'd1);
  endtask

  logic [31:0] pcq[$];
  logic [31:0] exp_pc;
  logic [31:0] next_pc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    drive(0, '0, 0, 0, 0, 0, 0);

    // 8 fills, 9th refused, 8 correct taken resolves, then idle
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 32'h8000_0000 + 32'(4*i), 1, 1, 0, 0, 0,
                        (i < 8), 0, 32'h0, 0, 0, 0, i, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8000_0024, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 8, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 1,
                        1, 1, 32'h8000_0000 + 32'(4*i), 1, 1, 0, 8 - i, 0, i, i));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0020, 1, 1, 0, 0, 0, 8, 8));
    // 4 queued, head mispredicted taken; same-cycle enqueue dropped
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'h100 + 32'(4*i), 1, 1, 0, 0, 0,
                        1, 0, 32'h8000_0020, 1, 1, 0, i + 1, 0, 8, 8));
    vecs.push_back(mk(1, 32'h200, 1, 1, 1, 0, 1, 0, 1, 32'h100, 0, 1, 1, 0, 0, 9, 8));
    // RECOVER cycle: enqueue refused, resolve ignored without underflow
    vecs.push_back(mk(1, 32'h300, 1, 1, 1, 0, 1, 1, 0, 32'h100, 0, 1, 0, 0, 0, 9, 8));
    // non-branch predicted as branch
    vecs.push_back(mk(1, 32'h400, 1, 1, 0, 0, 0, 1, 0, 32'h100, 0, 1, 0, 1, 0, 9, 8));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 0, 0, 1, 32'h400, 0, 0, 1, 0, 0, 9, 8));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h400, 0, 0, 0, 0, 0, 9, 8));
    // correct non-branch does not count; correct not-taken branch does
    vecs.push_back(mk(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 32'h400, 0, 0, 0, 1, 0, 9, 8));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 0, 1, 1, 32'h500, 0, 0, 0, 0, 0, 9, 8));
    vecs.push_back(mk(1, 32'h600, 0, 1, 0, 0, 0, 1, 0, 32'h500, 0, 0, 0, 1, 0, 9, 8));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 1, 1, 1, 32'h600, 0, 1, 0, 0, 0, 10, 9));
    // resolve on empty queue: sticky underflow
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 1, 1, 0, 32'h600, 0, 1, 0, 0, 1, 10, 9));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h600, 0, 1, 0, 0, 1, 10, 9));

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ev, vecs[i].epc, vecs[i].ept, vecs[i].epb,
            vecs[i].rv, vecs[i].rt, vecs[i].rb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d enq_ready", i), 64'(bus.enq_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d upd_valid", i), 64'(bus.upd_valid), 64'(vecs[i].uv));
      chk($sformatf("v%0d upd_pc", i), 64'(bus.upd_pc), 64'(vecs[i].upc));
      chk($sformatf("v%0d upd_taken", i), 64'(bus.upd_taken), 64'(vecs[i].ut));
      chk($sformatf("v%0d upd_br", i), 64'(bus.upd_is_branch), 64'(vecs[i].ub));
      chk($sformatf("v%0d mispred", i), 64'(bus.mispredict), 64'(vecs[i].mis));
      chk($sformatf("v%0d occ", i), 64'(bus.occupancy), 64'(vecs[i].occ));
      chk($sformatf("v%0d uflow", i), 64'(bus.underflow_err), 64'(vecs[i].uf));
      chk($sformatf("v%0d total", i), 64'(bus.total_cnt), 64'(vecs[i].tot));
      chk($sformatf("v%0d correct", i), 64'(bus.correct_cnt), 64'(vecs[i].cor));
    end

    // wrap: prime 3 entries, then 20 concurrent enqueue+resolve cycles
    next_pc = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      drive(1, next_pc, 1, 1, 0, 0, 0);
      pcq.push_back(next_pc);
      next_pc += 32'd4;
      @(posedge clk);
      #1;
    end
    chk("wrap prime occ", 64'(bus.occupancy), 64'd3);
    for (int i = 0; i < 20; i++) begin
      drive(1, next_pc, 1, 1, 1, 1, 1);
      pcq.push_back(next_pc);
      next_pc += 32'd4;
      exp_pc = pcq.pop_front();
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d occ", i), 64'(bus.occupancy), 64'd3);
      chk($sformatf("wrap%0d upd_valid", i), 64'(bus.upd_valid), 64'd1);
      chk($sformatf("wrap%0d upd_pc", i), 64'(bus.upd_pc), 64'(exp_pc));
      chk($sformatf("wrap%0d mispred", i), 64'(bus.mispredict), 64'd0);
    end
    chk("wrap total", 64'(bus.total_cnt), 64'd30);
    chk("wrap correct", 64'(bus.correct_cnt), 64'd29);

    // asynchronous reset mid-stream, inputs still active
    #2 reset = 1'b0;
    #1 chk_zero("async rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, '0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d upd_valid", i), 64'(bus.upd_valid), 64'd0);
      chk($sformatf("post%0d mispred", i), 64'(bus.mispredict), 64'd0);
      chk($sformatf("post%0d occ", i), 64'(bus.occupancy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between the fetch-stage branch_predictor and the execute-stage branch unit.
- Buffers each prediction made at fetch, in program order, together with its PC.
- When execute resolves the oldest in-flight control-flow instruction, the block compares the outcome against the stored prediction.
- It then drives the training interface of branch_predictor (pc, branch_taken_actual, is_branch_actual), raises a flush on misprediction, and keeps accuracy counters.

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- PC_W, 32, PC width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enq_valid  in  1  fetch presents a predicted instruction.
- enq_ready  out  1  queue accepts enqueue this cycle.
- enq_pc  in  PC_W  PC of the fetched instruction.
- enq_pred_taken  in  1  predictor `prediction`.
- enq_pred_branch  in  1  predictor `is_branch_predicted`.
- res_valid  in  1  execute resolves the oldest entry.
- res_taken  in  1  actual taken outcome.
- res_is_branch  in  1  instruction actually was a branch/jump.
- upd_valid  out  1  training strobe to the predictor.
- upd_pc  out  PC_W  PC being trained.
- upd_taken  out  1  drives branch_taken_actual.
- upd_is_branch  out  1  drives is_branch_actual.
- mispredict  out  1  one-cycle flush pulse to fetch.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- underflow_err  out  1  sticky; set when res_valid arrives while empty.
- total_cnt  out  CNT_W  resolved entries with res_is_branch=1.
- correct_cnt  out  CNT_W  of those, entries with pred_taken==res_taken.

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, occupancy=0, state=RUN, all outputs 0 except enq_ready=1. underflow_err and both counters clear.
- Storage: circular buffer of {pc, pred_taken, pred_branch}. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately, so full (==DEPTH) and empty (==0) are unambiguous.
- enq_ready = (state==RUN) && (occupancy<DEPTH). It is based on registered occupancy; same-cycle dequeue does not free a slot for enqueue.
- Enqueue fires on enq_valid && enq_ready.
- Resolve fires on res_valid && occupancy!=0. It pops the head entry.
- When res_valid arrives with occupancy==0, the event is ignored and underflow_err is set. underflow_err clears only on reset.
- Training output, registered, one cycle after resolve:
  - upd_valid=1.
  - upd_pc = head pc.
  - upd_taken = res_taken.
  - upd_is_branch = res_is_branch.
  - Otherwise upd_valid=0, and the upd_* data fields hold their last values.
- Mispredict condition on resolve: (pred_branch != res_is_branch) OR (res_is_branch && pred_taken != res_taken).
- On mispredict:
  - mispredict=1 for exactly the following cycle, concurrent with upd_valid.
  - All entries are discarded: occupancy→0, rd_ptr=wr_ptr.
  - Any enqueue firing in the same cycle is dropped.
  - state→RECOVER.
- State machine:
  - RUN: normal operation. A mispredicting resolve → RECOVER.
  - RECOVER: lasts exactly 1 cycle, with enq_ready=0. res_valid is ignored and does not set underflow_err. Then → RUN.
- Simultaneous enqueue + non-mispredicting resolve: occupancy unchanged, both pointers advance. This is legal at any occupancy between 1 and DEPTH-1, and at DEPTH only as a pure resolve.
- Counters, on each resolve with res_is_branch=1:
  - total_cnt increments.
  - correct_cnt increments when pred_taken==res_taken.
  - Both saturate at all-ones.
  - Entries with res_is_branch=0 do not count.
- Reset asserted mid-operation discards everything immediately. No upd_valid or mispredict pulse is emitted for in-flight entries.

Test Plan:
- Reset then 8 enqueues, pc=0x8000_0004..0x8000_0020 step 4: occupancy=8, enq_ready=0 on the 9th cycle, 9th enq_valid not accepted.
- Full queue of 8 correctly predicted taken branches, resolved res_taken=1 each cycle: 8 upd_valid pulses one cycle after each resolve, pc in enqueue order. mispredict never asserts; total_cnt=8, correct_cnt=8; occupancy returns to 0.
- 4 entries queued, head pred_taken=1, resolved res_taken=0, res_is_branch=1: next cycle upd_valid=1, upd_taken=0, mispredict=1, occupancy=0. enq_ready=0 for one cycle then 1; correct_cnt unchanged, total_cnt+1.
- Non-branch predicted as branch (pred_branch=1, res_is_branch=0, res_taken=0): mispredict=1, upd_is_branch=0, total_cnt unchanged.
- res_valid on empty queue: no upd_valid, underflow_err=1 and stays 1 until reset.
- Pointer wrap, DEPTH=8: 20 cycles of concurrent enqueue+resolve at occupancy 3: occupancy stays 3 and upd_pc sequence matches enqueue order across wrap. Then pull reset low mid-stream: all outputs zero asynchronously, with no pulses afterward.
